diskemu_arbiter: RTL and testbench
==================================

DISKEMU_ARBITER -- requirements
Module: diskemu_arbiter

Interface
REQ-001 Parameters SHALL be: BANK_BITS, 2, bank-select width (2^BANK_BITS banks); TURN_CYC, 2, bus-turnaround dead cycles (>=1); TIMEOUT, 1023, max Arduino ownership cycles (>=1); WP_MASK, 0, per-bank CoCo write-protect, width 2^BANK_BITS, bit n=1 protects bank n.
REQ-002 Ports SHALL be, clock and reset first:
- eclk  in  1  CoCo E clock; the only clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- c_power  in  1  CoCo powered.
- a_power  in  1  Arduino powered.
- ard_req  in  1  Arduino bus request, active-high.
- ard_oe  in  1  Arduino EEPROM read strobe, active-high.
- ard_we  in  1  Arduino EEPROM write strobe, active-high.
- ard_bank  in  BANK_BITS  bank driven while Arduino owns the bus.
- ard_clr  in  1  clear sticky flags, one-cycle pulse.
- cts  in  1  CoCo cartridge ROM select, active-low.
- scs  in  1  CoCo cartridge I/O select, active-low.
- coco_rw  in  1  CoCo R/W; 1=read.
- coco_data  in  BANK_BITS  CoCo data bits for bank register write.
- c_busen  out  1  CoCo address buffer enable, active-low.
- ard_grant  out  1  Arduino owns address bus, active-high.
- bank  out  BANK_BITS  EEPROM bank address.
- een  out  1  EEPROM output enable, active-low.
- wee  out  1  EEPROM write enable, active-low.
- status  out  3  {wp_flag, timeout_flag, ard_grant}.

Function
REQ-003 FSM SHALL have states COCO, DRAIN, ARD, RELEASE; all outputs are decoded from registered state and registered flags plus the listed inputs.
REQ-004 COCO: c_busen=0, ard_grant=0; SHALL go to DRAIN when ard_req & a_power & cts & scs (no cartridge cycle in progress); otherwise stay.
REQ-005 DRAIN: c_busen=1, ard_grant=0; SHALL hold exactly TURN_CYC cycles, then go to ARD; if ard_req or a_power drops during DRAIN, SHALL go to RELEASE.
REQ-006 ARD: c_busen=1, ard_grant=1; ownership counter increments each cycle from 0; SHALL go to RELEASE when ard_req=0 or a_power=0, or when counter reaches TIMEOUT-1 (grant lasts at most TIMEOUT cycles).
REQ-007 Timeout exit SHALL set timeout_flag; ard_req release on that same cycle SHALL NOT set it.
REQ-008 RELEASE: c_busen=1, ard_grant=0; SHALL hold exactly TURN_CYC cycles then go to COCO; ard_req ignored in RELEASE; COCO SHALL last at least one cycle before re-entering DRAIN.
REQ-009 Counter width SHALL be clog2(TIMEOUT+1); counter SHALL clear on entry to DRAIN, ARD, RELEASE; no wrap is reachable.
REQ-010 Bank register SHALL load coco_data on a cycle in COCO with c_power=1, scs=0, coco_rw=0; otherwise hold, including across ARD.
REQ-011 bank SHALL equal ard_bank in ARD, else the bank register.
REQ-012 een SHALL be cts in COCO, ~ard_oe in ARD, 1 in DRAIN/RELEASE.
REQ-013 wee in COCO SHALL be 0 only when cts=0, coco_rw=0, WP_MASK[bank]=0; in ARD SHALL be ~ard_we (write-protect not applied to Arduino); 1 in DRAIN/RELEASE.
REQ-014 CoCo write attempt (COCO, cts=0, coco_rw=0) to a protected bank SHALL set wp_flag.
REQ-015 Flags SHALL be sticky until ard_clr=1; simultaneous set and clear: set wins.
REQ-016 c_power=0 SHALL NOT block arbitration; cts/scs treated as given.

Reset
REQ-017 On rst=1 at a clock edge SHALL force: state COCO, counter 0, bank register 0, timeout_flag 0, wp_flag 0; outputs then c_busen=0, ard_grant=0, bank=0, een=cts, wee=1, status=000.
REQ-018 rst mid-ARD SHALL return to COCO next cycle with no RELEASE dead time; rst overrides all other inputs.

Verification
REQ-019 Handover: TURN_CYC=2, ard_req=1, cts=scs=1 from COCO -> c_busen=1 at edge 1, ard_grant=1 after edge 3; drop ard_req -> ard_grant=0 next edge, c_busen=0 two cycles later.
REQ-020 Blocked request: ard_req=1 with cts=0 held 5 cycles -> stays COCO, c_busen=0; cts=1 -> DRAIN next edge.
REQ-021 Timeout: TIMEOUT=4, ard_req held 1 -> ard_grant high exactly 4 cycles, timeout_flag=1, status[1]=1; ard_clr pulse -> 0.
REQ-022 Bank/WP: WP_MASK=4'b0100, CoCo writes coco_data=2 via scs=0, coco_rw=0 -> bank=2; CoCo write cts=0 -> wee stays 1, wp_flag=1; same in bank 1 -> wee=0.
REQ-023 Arduino view: in ARD, ard_bank=3, ard_oe=1 -> bank=3, een=0; back in COCO bank returns to stored 2.
REQ-024 Reset mid-ARD: rst asserted -> next cycle c_busen=0, ard_grant=0, bank=0, flags cleared.

Source files
------------

// File: rtl/diskemu_arbiter.sv
// Bus arbiter between the CoCo cartridge port and an Arduino loader sharing one
// banked EEPROM; handles turnaround dead time, ownership timeout and write-protect.
module diskemu_arbiter #(
    parameter int                             BANK_BITS = 2,
    parameter int                             TURN_CYC  = 2,
    parameter int                             TIMEOUT   = 1023,
    parameter logic [(2**BANK_BITS)-1:0]      WP_MASK   = '0
) (
    input  logic                 eclk,
    input  logic                 rst,
    input  logic                 c_power,
    input  logic                 a_power,
    input  logic                 ard_req,
    input  logic                 ard_oe,
    input  logic                 ard_we,
    input  logic [BANK_BITS-1:0] ard_bank,
    input  logic                 ard_clr,
    input  logic                 cts,
    input  logic                 scs,
    input  logic                 coco_rw,
    input  logic [BANK_BITS-1:0] coco_data,
    output logic                 c_busen,
    output logic                 ard_grant,
    output logic [BANK_BITS-1:0] bank,
    output logic                 een,
    output logic                 wee,
    output logic [2:0]           status
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_COCO    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_ARD     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Last counter value of each timed state; DRAIN/RELEASE share TURN_LAST.
    localparam logic [CNT_W-1:0] TURN_LAST    = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]           state;
    logic [1:0]           state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [BANK_BITS-1:0] bank_reg;
    logic                 timeout_flag;
    logic                 wp_flag;
    logic                 timeout_hit;
    logic                 ard_active;
    logic                 bank_load;
    logic                 coco_write;
    logic                 wp_set;

    assign ard_active = ard_req & a_power;
    assign bank_load  = (state == ST_COCO) & c_power & ~scs & ~coco_rw;
    assign coco_write = (state == ST_COCO) & ~cts & ~coco_rw;
    assign wp_set     = coco_write & WP_MASK[bank_reg];

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_nx    = state;
        timeout_hit = 1'b0;
        case (state)
            ST_COCO: begin
                if (ard_active && cts && scs)
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!ard_active)
                    state_nx = ST_RELEASE;
                else if (cnt == TURN_LAST)
                    state_nx = ST_ARD;
            end
            ST_ARD: begin
                // A voluntary release on the final cycle is not a timeout.
                if (!ard_active) begin
                    state_nx = ST_RELEASE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx    = ST_RELEASE;
                    timeout_hit = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt == TURN_LAST)
                    state_nx = ST_COCO;
            end
            default: state_nx = ST_COCO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge eclk) begin
        if (rst) begin
            state        <= ST_COCO;
            cnt          <= '0;
            bank_reg     <= '0;
            timeout_flag <= 1'b0;
            wp_flag      <= 1'b0;
        end else begin
            state <= state_nx;

            // Counter is idle in COCO and restarts on every state change.
            if (state_nx != state)
                cnt <= '0;
            else if (state != ST_COCO)
                cnt <= cnt + 1'b1;

            if (bank_load)
                bank_reg <= coco_data;

            if (timeout_hit)
                timeout_flag <= 1'b1;
            else if (ard_clr)
                timeout_flag <= 1'b0;

            if (wp_set)
                wp_flag <= 1'b1;
            else if (ard_clr)
                wp_flag <= 1'b0;
        end
    end

    always_comb begin
        c_busen   = (state != ST_COCO);
        ard_grant = (state == ST_ARD);
        bank      = ard_grant ? ard_bank : bank_reg;
        een       = 1'b1;
        wee       = 1'b1;
        case (state)
            ST_COCO: begin
                een = cts;
                wee = ~(coco_write & ~WP_MASK[bank_reg]);
            end
            ST_ARD: begin
                een = ~ard_oe;
                wee = ~ard_we;
            end
            default: begin
                een = 1'b1;
                wee = 1'b1;
            end
        endcase
        status = {wp_flag, timeout_flag, ard_grant};
    end

endmodule

// File: tb/tb_diskemu_arbiter.sv
// Self-checking bench for diskemu_arbiter: directed handover/timeout/bank scenarios
// followed by randomized traffic, all compared against a phase-level model.
module tb_diskemu_arbiter;

    localparam int          BANK_BITS = 2;
    localparam int          TURN_CYC  = 2;
    localparam int          TIMEOUT   = 4;
    localparam logic [3:0]  WP        = 4'b0100;

    logic       eclk = 1'b0;
    logic       rst = 1'b1;
    logic       c_power = 1'b1;
    logic       a_power = 1'b1;
    logic       ard_req = 1'b0;
    logic       ard_oe = 1'b0;
    logic       ard_we = 1'b0;
    logic [1:0] ard_bank = '0;
    logic       ard_clr = 1'b0;
    logic       cts = 1'b1;
    logic       scs = 1'b1;
    logic       coco_rw = 1'b1;
    logic [1:0] coco_data = '0;
    logic       c_busen;
    logic       ard_grant;
    logic [1:0] bank;
    logic       een;
    logic       wee;
    logic [2:0] status;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    diskemu_arbiter #(
        .BANK_BITS (BANK_BITS),
        .TURN_CYC  (TURN_CYC),
        .TIMEOUT   (TIMEOUT),
        .WP_MASK   (WP)
    ) dut (
        .eclk      (eclk),
        .rst       (rst),
        .c_power   (c_power),
        .a_power   (a_power),
        .ard_req   (ard_req),
        .ard_oe    (ard_oe),
        .ard_we    (ard_we),
        .ard_bank  (ard_bank),
        .ard_clr   (ard_clr),
        .cts       (cts),
        .scs       (scs),
        .coco_rw   (coco_rw),
        .coco_data (coco_data),
        .c_busen   (c_busen),
        .ard_grant (ard_grant),
        .bank      (bank),
        .een       (een),
        .wee       (wee),
        .status    (status)
    );

    always #5 eclk = ~eclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge eclk);
            #1;
        end
    endtask

    // Phase-level model: each timed phase carries a countdown of cycles left.
    typedef enum {M_COCO, M_DRAIN, M_ARD, M_REL} mphase_t;
    mphase_t    m_phase = M_COCO;
    int         m_left = 0;
    logic [1:0] m_bank = '0;
    bit         m_to = 1'b0;
    bit         m_wp = 1'b0;

    always @(posedge eclk) begin
        if (rst) begin
            m_phase <= M_COCO;
            m_left  <= 0;
            m_bank  <= '0;
            m_to    <= 1'b0;
            m_wp    <= 1'b0;
        end else begin
            if (m_phase == M_COCO && c_power && !scs && !coco_rw)
                m_bank <= coco_data;
            if (m_phase == M_COCO && !cts && !coco_rw && WP[m_bank])
                m_wp <= 1'b1;
            else if (ard_clr)
                m_wp <= 1'b0;
            if (m_phase == M_ARD && ard_req && a_power && m_left == 1)
                m_to <= 1'b1;
            else if (ard_clr)
                m_to <= 1'b0;
            case (m_phase)
                M_COCO: if (ard_req && a_power && cts && scs) begin
                    m_phase <= M_DRAIN;
                    m_left  <= TURN_CYC;
                end
                M_DRAIN: if (!(ard_req && a_power)) begin
                    m_phase <= M_REL;
                    m_left  <= TURN_CYC;
                end else if (m_left == 1) begin
                    m_phase <= M_ARD;
                    m_left  <= TIMEOUT;
                end else begin
                    m_left <= m_left - 1;
                end
                M_ARD: if (!(ard_req && a_power) || m_left == 1) begin
                    m_phase <= M_REL;
                    m_left  <= TURN_CYC;
                end else begin
                    m_left <= m_left - 1;
                end
                M_REL: if (m_left == 1) m_phase <= M_COCO;
                       else m_left <= m_left - 1;
                default: m_phase <= M_COCO;
            endcase
        end
    end

    always @(negedge eclk) begin
        if (check_en) begin
            check("c_busen", c_busen, m_phase != M_COCO);
            check("ard_grant", ard_grant, m_phase == M_ARD);
            check("bank", bank, (m_phase == M_ARD) ? ard_bank : m_bank);
            check("een", een, (m_phase == M_COCO) ? cts :
                              (m_phase == M_ARD) ? !ard_oe : 1'b1);
            check("wee", wee, (m_phase == M_COCO) ? !(!cts && !coco_rw && !WP[m_bank]) :
                              (m_phase == M_ARD) ? !ard_we : 1'b1);
            check("status", status, {m_wp, m_to, m_phase == M_ARD});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset state
        tick(2);
        check_en = 1'b1;
        rst = 1'b0;
        check("rst_c_busen", c_busen, 1'b0);
        check("rst_ard_grant", ard_grant, 1'b0);
        check("rst_bank", bank, 2'd0);
        check("rst_wee", wee, 1'b1);
        check("rst_status", status, 3'b000);
        cts = 1'b0;
        #1;
        check("rst_een_follows_cts", een, 1'b0);
        cts = 1'b1;
        tick();

        // Handover and release timing
        ard_req = 1'b1;
        tick();
        check("ho_busen_edge1", c_busen, 1'b1);
        check("ho_grant_edge1", ard_grant, 1'b0);
        tick();
        check("ho_grant_edge2", ard_grant, 1'b0);
        tick();
        check("ho_grant_edge3", ard_grant, 1'b1);
        ard_req = 1'b0;
        tick();
        check("ho_grant_dropped", ard_grant, 1'b0);
        check("ho_busen_release", c_busen, 1'b1);
        tick();
        check("ho_busen_release2", c_busen, 1'b1);
        tick();
        check("ho_busen_back", c_busen, 1'b0);

        // Request blocked by an active cartridge cycle
        cts = 1'b0;
        ard_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("blk_busen", c_busen, 1'b0);
        end
        cts = 1'b1;
        tick();
        check("blk_drain", c_busen, 1'b1);
        ard_req = 1'b0;
        tick(3);
        check("blk_back_coco", c_busen, 1'b0);

        // Ownership timeout
        ard_req = 1'b1;
        tick(3);
        n = 0;
        while (ard_grant && n < 20) begin
            n++;
            tick();
        end
        check("to_grant_cycles", n, TIMEOUT);
        check("to_flag", status[1], 1'b1);
        ard_req = 1'b0;
        ard_clr = 1'b1;
        tick();
        ard_clr = 1'b0;
        check("to_flag_cleared", status[1], 1'b0);
        tick();

        // Release on the final allowed cycle does not count as timeout
        ard_req = 1'b1;
        tick(3);
        check("to_edge_grant", ard_grant, 1'b1);
        tick(3);
        ard_req = 1'b0;
        tick();
        check("to_edge_released", ard_grant, 1'b0);
        check("to_edge_no_flag", status[1], 1'b0);
        tick(2);

        // Bank register load and write-protect
        scs = 1'b0; coco_rw = 1'b0; coco_data = 2'd2;
        tick();
        scs = 1'b1;
        check("bank_loaded", bank, 2'd2);
        cts = 1'b0;
        #1;
        check("wp_wee_blocked", wee, 1'b1);
        tick();
        cts = 1'b1; coco_rw = 1'b1;
        check("wp_flag_set", status[2], 1'b1);
        ard_clr = 1'b1;
        tick();
        ard_clr = 1'b0;
        check("wp_flag_cleared", status[2], 1'b0);
        scs = 1'b0; coco_rw = 1'b0; coco_data = 2'd1;
        tick();
        scs = 1'b1; cts = 1'b0;
        #1;
        check("wp_bank1_wee", wee, 1'b0);
        tick();
        cts = 1'b1; coco_rw = 1'b1;
        check("wp_bank1_noflag", status[2], 1'b0);
        scs = 1'b0; coco_rw = 1'b0; coco_data = 2'd2;
        tick();
        scs = 1'b1; coco_rw = 1'b1;

        // Arduino view of the bank and strobes
        ard_req = 1'b1; ard_bank = 2'd3; ard_oe = 1'b1;
        tick(3);
        check("ard_bank", bank, 2'd3);
        check("ard_een", een, 1'b0);
        ard_req = 1'b0; ard_oe = 1'b0;
        tick(3);
        check("coco_bank_restored", bank, 2'd2);

        // Reset mid-ownership
        cts = 1'b0; coco_rw = 1'b0;
        tick();
        cts = 1'b1; coco_rw = 1'b1;
        check("mid_wp_flag", status[2], 1'b1);
        ard_req = 1'b1;
        tick(3);
        check("mid_grant", ard_grant, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; ard_req = 1'b0;
        check("mid_rst_busen", c_busen, 1'b0);
        check("mid_rst_grant", ard_grant, 1'b0);
        check("mid_rst_bank", bank, 2'd0);
        check("mid_rst_status", status, 3'b000);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) ard_req = ~ard_req;
            a_power   = ($urandom_range(0, 39) != 0);
            c_power   = ($urandom_range(0, 9) != 0);
            cts       = ($urandom_range(0, 4) != 0);
            scs       = ($urandom_range(0, 5) != 0);
            coco_rw   = 1'($urandom_range(0, 1));
            coco_data = 2'($urandom_range(0, 3));
            ard_bank  = 2'($urandom_range(0, 3));
            ard_oe    = 1'($urandom_range(0, 1));
            ard_we    = 1'($urandom_range(0, 1));
            ard_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
